// File: rtl/clb_pkg.sv
// Shared types and sizes for the clb_ecb block sequencer.
// Used by clb_ecb_seq, clb_out_reg and clb_ecb_seq_if.
package clb_pkg;

  localparam int BLK_W      = 128;
  localparam int KEY_W      = 256;
  localparam int CLB_ROUNDS = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } clb_state_t;

endpackage

// File: rtl/clb_ecb_seq_if.sv
// 128-bit valid/ready block stream.
// master drives data/valid, slave drives ready.
interface clb_ecb_seq_if;
  import clb_pkg::*;

  logic [BLK_W-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/clb_out_reg.sv
// Ciphertext holding register with valid/ready drain.
// A capture in the same cycle as a drain wins and keeps valid high.
module clb_out_reg
  import clb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cap,
  input  logic [BLK_W-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [BLK_W-1:0] o_data
);

  logic             r_valid;
  logic [BLK_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_cap) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/clb_ecb_seq.sv
// Streams blocks through the single-shot clb_ecb core.
// Define CLB_SEQ_CBC_EN to build the CBC chaining register.
module clb_ecb_seq
  import clb_pkg::*;
#(
  parameter int ROUNDS   = CLB_ROUNDS,
  parameter int WAIT_MAX = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_we,
  clb_ecb_seq_if.slave     s_in,
  clb_ecb_seq_if.master    m_out,
  output logic             core_rst,
  output logic [BLK_W-1:0] core_textin,
  output logic [KEY_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_textout,
  input  logic             core_enable,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  clb_state_t       r_state;
  logic             r_rdy;
  logic             r_crst;
  logic             r_err;
  logic [BLK_W-1:0] r_text;
  logic [KEY_W-1:0] r_key;
  logic [CNT_W-1:0] r_cnt;
  logic [WW-1:0]    r_wait;

  logic             w_acc;
  logic             w_kwe;
  logic             w_cap;
  logic             w_tmo;
  logic             w_drain;
  logic             w_ovalid;
  logic [BLK_W-1:0] w_odata;
  logic [BLK_W-1:0] w_blk;

  assign w_acc   = (r_state == ST_IDLE) && s_in.valid && r_rdy;
  assign w_kwe   = (r_state == ST_IDLE) && key_we;
  // a finished core waits in RUN until the output slot frees
  assign w_cap   = (r_state == ST_RUN) && core_enable &&
                   (!w_ovalid || m_out.ready);
  assign w_tmo   = (r_state == ST_RUN) && !core_enable &&
                   (r_wait == WW'(WAIT_MAX - 1));
  assign w_drain = w_ovalid && m_out.ready;

`ifdef CLB_SEQ_CBC_EN
  logic [BLK_W-1:0] r_chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chain <= '0;
    end else if (w_kwe) begin
      r_chain <= key_in[BLK_W-1:0];
    end else if (w_cap) begin
      r_chain <= core_textout;
    end
  end

  assign w_blk = s_in.data ^ r_chain;
`else
  assign w_blk = s_in.data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_rdy   <= 1'b0;
      r_crst  <= 1'b0;
      r_err   <= 1'b0;
      r_text  <= '0;
      r_key   <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
    end else begin
      if (w_kwe) r_key <= key_in;
      if (w_drain) r_cnt <= r_cnt + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          r_rdy  <= 1'b1;
          r_crst <= 1'b0;
          if (w_acc) begin
            r_text  <= w_blk;
            r_rdy   <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_wait  <= '0;
          r_crst  <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_cap || w_tmo) begin
            r_state <= ST_IDLE;
            r_crst  <= 1'b0;
            r_rdy   <= 1'b1;
            if (w_tmo) r_err <= 1'b1;
          end else if (!core_enable) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_crst  <= 1'b0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  clb_out_reg u_out (
    .clk     (clk),
    .rst     (rst),
    .i_cap   (w_cap),
    .i_data  (core_textout),
    .i_ready (m_out.ready),
    .o_valid (w_ovalid),
    .o_data  (w_odata)
  );

  assign s_in.ready   = r_rdy;
  assign m_out.valid  = w_ovalid;
  assign m_out.data   = w_odata;
  assign core_rst     = r_crst;
  assign core_textin  = r_text;
  assign core_key     = r_key;
  assign busy         = (r_state != ST_IDLE);
  assign err_timeout  = r_err;
  assign blk_cnt      = r_cnt;

endmodule

// File: tb/tb_clb_ecb_seq.sv
// Scoreboard bench for clb_ecb_seq with a behavioural core stub.
// Core stub raises done ROUNDS+1 cycles after load release.
module tb_clb_ecb_seq;
  import clb_pkg::*;

  localparam int ROUNDS = 24;
  localparam int WMAX   = 31;

  logic             clk = 0;
  logic             rst = 0;
  logic [KEY_W-1:0] key_in = '0;
  logic             key_we = 0;
  logic             core_rst;
  logic [BLK_W-1:0] core_textin;
  logic [KEY_W-1:0] core_key;
  logic [BLK_W-1:0] core_textout;
  logic             core_enable;
  logic             busy;
  logic             err_timeout;
  logic [15:0]      blk_cnt;

  clb_ecb_seq_if u_in ();
  clb_ecb_seq_if u_out ();

  clb_ecb_seq #(
    .ROUNDS   (ROUNDS),
    .WAIT_MAX (WMAX),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_we       (key_we),
    .s_in         (u_in),
    .m_out        (u_out),
    .core_rst     (core_rst),
    .core_textin  (core_textin),
    .core_key     (core_key),
    .core_textout (core_textout),
    .core_enable  (core_enable),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .blk_cnt      (blk_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] cipher(
    input logic [127:0] t, input logic [255:0] k);
    return {t[94:0], t[127:95]} ^ k[127:0] ^ k[255:128] ^
           128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  // core stub
  logic [5:0]   c_cnt = '0;
  logic [127:0] c_txt = '0;
  logic [255:0] c_key = '0;
  logic         tie_off = 0;

  always @(posedge clk) begin
    if (!core_rst) begin
      c_cnt <= '0;
      c_txt <= core_textin;
      c_key <= core_key;
    end else if (c_cnt != 6'(ROUNDS + 1)) begin
      c_cnt <= c_cnt + 1'b1;
    end
  end

  assign core_enable  = !tie_off && core_rst &&
                        (c_cnt == 6'(ROUNDS + 1));
  assign core_textout = core_enable ? cipher(c_txt, c_key) : '0;

  // checking
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] e;
    longint       t;
  } ent_t;

  ent_t         sb[$];
  logic [255:0] key_m   = '0;
  logic [127:0] chain_m = '0;
  longint       t_acc   = 0;

  // monitor: latency on valid rise, data on handshake
  logic pv = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pv <= 1'b0;
    end else begin
      if (u_out.valid && !pv && sb.size() != 0)
        chk("lat", 256'(($time - 5 - sb[0].t) / 10), 256'd27);
      if (u_out.valid && u_out.ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 256'(u_out.data), 256'hx);
        end else begin
          chk("data", 256'(u_out.data), 256'(sb[0].e));
          sb.pop_front();
        end
      end
      pv <= u_out.valid;
    end
  end

  task automatic set_key(input logic [255:0] k);
    key_in = k;
    key_we = 1;
    @(posedge clk); #1;
    key_we = 0;
    key_m   = k;
    chain_m = k[127:0];
  endtask

  task automatic send(input logic [127:0] d, input bit expo);
    logic [127:0] t;
    logic [127:0] e;
    int n;
    n = 0;
    u_in.data  = d;
    u_in.valid = 1;
    while (!u_in.ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      chk("rdy_to", 256'(u_in.ready), 256'd1);
      u_in.valid = 0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    #1;
    u_in.valid = 0;
`ifdef CLB_SEQ_CBC_EN
    t = d ^ chain_m;
`else
    t = d;
`endif
    e = cipher(t, key_m);
    chk("txtin", 256'(core_textin), 256'(t));
    chk("crst_ld", 256'(core_rst), 256'd0);
    chk("rdy_bsy", 256'(u_in.ready), 256'd0);
    if (expo) begin
      sb.push_back('{e: e, t: t_acc});
      chain_m = e;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 256'(sb.size()), 256'd0);
  endtask

  longint t1, t2, t3;

  initial begin
    u_in.data   = '0;
    u_in.valid  = 0;
    u_out.ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 256'(u_in.ready), 256'd0);
    chk("rst_ov", 256'(u_out.valid), 256'd0);
    chk("rst_od", 256'(u_out.data), 256'd0);
    chk("rst_crst", 256'(core_rst), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_err", 256'(err_timeout), 256'd0);
    chk("rst_cnt", 256'(blk_cnt), 256'd0);
    rst = 1;
    @(posedge clk); #1;
    chk("idle_rdy", 256'(u_in.ready), 256'd1);

    // single block
    set_key('0);
    send('0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("crst_run", 256'(core_rst), 256'd1);
    drain();
    chk("cnt1", 256'(blk_cnt), 256'd1);

    // back-to-back
    send(128'h1, 1); t1 = t_acc;
    send(128'h2, 1); t2 = t_acc;
    send(128'h3, 1); t3 = t_acc;
    chk("gap12", 256'((t2 - t1) / 10), 256'd28);
    chk("gap23", 256'((t3 - t2) / 10), 256'd28);
    drain();
    chk("cnt4", 256'(blk_cnt), 256'd4);

    // output stall across two blocks
    u_out.ready = 0;
    send(128'hdead_beef, 1);
    send(128'h1234_5678_9abc, 1);
    repeat (32) @(posedge clk);
    #1;
    chk("stl_busy", 256'(busy), 256'd1);
    chk("stl_crst", 256'(core_rst), 256'd1);
    chk("stl_ov", 256'(u_out.valid), 256'd1);
    chk("stl_hold", 256'(u_out.data), 256'(sb[0].e));
    u_out.ready = 1;
    @(posedge clk); #1;
    chk("stl_cap", 256'(u_out.valid), 256'd1);
    chk("stl_idle", 256'(busy), 256'd0);
    drain();
    chk("cnt6", 256'(blk_cnt), 256'd6);

    // timeout
    tie_off = 1;
    send(128'h77, 0);
    repeat (31) @(posedge clk);
    #1;
    chk("tmo_pre", 256'(err_timeout), 256'd0);
    chk("tmo_bsy", 256'(busy), 256'd1);
    @(posedge clk); #1;
    chk("tmo_err", 256'(err_timeout), 256'd1);
    chk("tmo_idle", 256'(busy), 256'd0);
    chk("tmo_ov", 256'(u_out.valid), 256'd0);
    tie_off = 0;
    send(128'h88, 1);
    drain();
    chk("cnt7", 256'(blk_cnt), 256'd7);
    chk("tmo_stk", 256'(err_timeout), 256'd1);

    // key write outside IDLE is ignored
    send(128'h99, 1);
    key_in = '1;
    key_we = 1;
    @(posedge clk); #1;
    key_we = 0;
    chk("key_hold", 256'(core_key), 256'(key_m));
    drain();

    // reset mid-RUN
    send(128'h55, 1);
    repeat (10) @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("mr_crst", 256'(core_rst), 256'd0);
    chk("mr_busy", 256'(busy), 256'd0);
    chk("mr_cnt", 256'(blk_cnt), 256'd0);
    chk("mr_err", 256'(err_timeout), 256'd0);
    chk("mr_rdy", 256'(u_in.ready), 256'd0);
    chk("mr_key", 256'(core_key), 256'd0);
    chk("mr_txt", 256'(core_textin), 256'd0);
    sb.delete();
    key_m   = '0;
    chain_m = '0;
    @(posedge clk); #1;
    rst = 1;

    // chaining IV in the low key half
    set_key({128'h0f0f, 128'ha5});
    send(128'h1111, 1);
    send(128'h2222, 1);
    drain();
    chk("cnt_end", 256'(blk_cnt), 256'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
